// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, writeback entry type and rd one-hot helper
package wb_arbiter_pkg;

    localparam int XLEN           = 64;
    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]           data;
    } wb_entry_t;

    // x0 is never a real destination, so its bit is forced low
    function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_WIDTH-1:0] rd);
        logic [31:0] m;
        m     = 32'd0;
        m[rd] = 1'b1;
        m[0]  = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - fast/slow result inputs and regfile write-port bundle
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                      fast_valid;
    logic [REG_ADDR_WIDTH-1:0] fast_rd;
    logic [XLEN-1:0]           fast_data;
    logic                      fast_stall;
    logic                      slow_valid;
    logic                      slow_ready;
    logic [REG_ADDR_WIDTH-1:0] slow_rd;
    logic [XLEN-1:0]           slow_data;
    logic                      rd_wen;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [XLEN-1:0]           rd_data;
    logic [31:0]               busy_mask;

    modport master (
        output fast_valid, fast_rd, fast_data, slow_valid, slow_rd, slow_data,
        input  fast_stall, slow_ready, rd_wen, rd_addr, rd_data, busy_mask
    );

    modport slave (
        input  fast_valid, fast_rd, fast_data, slow_valid, slow_rd, slow_data,
        output fast_stall, slow_ready, rd_wen, rd_addr, rd_data, busy_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous slow-result FIFO exposing per-entry valid and rd
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  wb_entry_t                            push_entry,
    input  logic                                 pop,
    output wb_entry_t                            head,
    output logic [$clog2(DEPTH):0]               count,
    output logic                                 full,
    output logic                                 empty,
    output logic [DEPTH-1:0]                     ent_valid,
    output logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] ent_rd
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = {1'b0, PW'(i) - rd_ptr_q} < count_q;
            ent_rd[i]    = mem_q[i].rd;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: fast path wins, slow results buffered and drained when idle
// Optional WB_PERF_EN adds perf_stall_cycles / perf_x0_drops counters.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    wb_arbiter_if.slave       bus
`ifdef WB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_x0_drops
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t                                 fifo_head, sel_entry, wb_q, wb_d;
    logic [CW-1:0]                             fifo_count;
    logic                                      fifo_full, fifo_empty;
    logic [FIFO_DEPTH-1:0]                     ent_valid;
    logic [FIFO_DEPTH-1:0][REG_ADDR_WIDTH-1:0] ent_rd;
    logic                                      push, pop, sel_valid, slow_ready;
    logic                                      rd_wen_q, rd_wen_d;
    logic                                      fast_stall_q, fast_stall_d;
    logic [SW-1:0]                             starve_cnt_q, starve_cnt_d;
    logic [31:0]                               busy;

    assign slow_ready = !fifo_full && !rst;
    assign push       = bus.slow_valid && slow_ready;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ('{rd: bus.slow_rd, data: bus.slow_data}),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd)
    );

    always_comb begin
        sel_valid = 1'b0;
        pop       = 1'b0;
        sel_entry = fifo_head;
        if (bus.fast_valid) begin
            sel_valid      = 1'b1;
            sel_entry.rd   = bus.fast_rd;
            sel_entry.data = bus.fast_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            pop       = 1'b1;
        end
        rd_wen_d = sel_valid && (sel_entry.rd != '0);
        wb_d     = rd_wen_d ? sel_entry : wb_q;
    end

    // Counter saturates at the limit; it only needs to tell "reached" from "not yet"
    always_comb begin
        starve_cnt_d = '0;
        if ((fifo_count != '0) && bus.fast_valid) begin
            starve_cnt_d = (starve_cnt_q == SW'(STARVE_LIMIT)) ? starve_cnt_q
                                                                : starve_cnt_q + SW'(1);
        end
        fast_stall_d = fast_stall_q;
        if (pop) begin
            fast_stall_d = 1'b0;
        end else if (starve_cnt_q == SW'(STARVE_LIMIT)) begin
            fast_stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wen_q     <= 1'b0;
            wb_q         <= '0;
            fast_stall_q <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            rd_wen_q     <= rd_wen_d;
            wb_q         <= wb_d;
            fast_stall_q <= fast_stall_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        busy = 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i]) begin
                busy = busy | rd_onehot(ent_rd[i]);
            end
        end
        if (rd_wen_q) begin
            busy = busy | rd_onehot(wb_q.rd);
        end
    end

    assign bus.slow_ready = slow_ready;
    assign bus.fast_stall = fast_stall_q;
    assign bus.rd_wen     = rd_wen_q;
    assign bus.rd_addr    = wb_q.rd;
    assign bus.rd_data    = wb_q.data;
    assign bus.busy_mask  = busy;

`ifdef WB_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d, x0_drops_q, x0_drops_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, fast_stall_q};
        x0_drops_d     = x0_drops_q + {31'd0, sel_valid && (sel_entry.rd == '0)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            x0_drops_q     <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            x0_drops_q     <= x0_drops_d;
        end
    end

    assign perf_stall_cycles = stall_cycles_q;
    assign perf_x0_drops     = x0_drops_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with a queue-based reference model
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

`ifdef WB_PERF_EN
    logic [31:0] perf_stall_cycles, perf_x0_drops;
`endif

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus)
`ifdef WB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_x0_drops     (perf_x0_drops)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic        wen;
        logic [31:0] busy;
        logic        stall;
        logic        ready;
        logic [31:0] pst;
        logic [31:0] px0;
    } st_t;

    st_t stq[$];
    wr_t wrq[$];
    wr_t mq[$];

    logic        m_wen   = 1'b0;
    logic [4:0]  m_addr  = 5'd0;
    logic        m_stall = 1'b0;
    int          m_run   = 0;
    logic [31:0] m_pst   = 32'd0;
    logic [31:0] m_px0   = 32'd0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = 32'd0;
        foreach (mq[i]) m = m | (32'd1 << mq[i].rd);
        if (m_wen) m = m | (32'd1 << m_addr);
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock cycle: drive inputs, record expectations, advance the model
    task automatic step(input logic r, input logic fv, input logic [4:0] frd, input logic [63:0] fd,
                        input logic sv, input logic [4:0] srd, input logic [63:0] sd);
        st_t  e;
        wr_t  sel;
        logic selv, popped, nonempty, ready;
        rst            = r;
        bus.fast_valid = fv;
        bus.fast_rd    = frd;
        bus.fast_data  = fd;
        bus.slow_valid = sv;
        bus.slow_rd    = srd;
        bus.slow_data  = sd;
        ready   = !r && (mq.size() < DEPTH);
        e.wen   = m_wen;
        e.busy  = model_busy();
        e.stall = m_stall;
        e.ready = ready;
        e.pst   = m_pst;
        e.px0   = m_px0;
        stq.push_back(e);
        if (r) begin
            mq.delete();
            m_wen   = 1'b0;
            m_addr  = 5'd0;
            m_stall = 1'b0;
            m_run   = 0;
            m_pst   = 32'd0;
            m_px0   = 32'd0;
        end else begin
            nonempty = (mq.size() > 0);
            popped   = 1'b0;
            selv     = 1'b0;
            sel.rd   = 5'd0;
            sel.data = 64'd0;
            if (fv) begin
                selv     = 1'b1;
                sel.rd   = frd;
                sel.data = fd;
            end else if (nonempty) begin
                selv   = 1'b1;
                sel    = mq.pop_front();
                popped = 1'b1;
            end
            m_pst = m_pst + {31'd0, m_stall};
            if (selv && sel.rd == 5'd0) m_px0 = m_px0 + 32'd1;
            m_wen = selv && (sel.rd != 5'd0);
            if (m_wen) begin
                m_addr = sel.rd;
                wrq.push_back(sel);
            end
            if (popped) m_stall = 1'b0;
            else if (m_run >= LIMIT) m_stall = 1'b1;
            m_run = (nonempty && fv) ? m_run + 1 : 0;
            if (sv && ready) begin
                wr_t s;
                s.rd   = srd;
                s.data = sd;
                mq.push_back(s);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    always @(negedge clk) begin
        st_t e;
        wr_t w;
        if (stq.size() > 0) begin
            e = stq.pop_front();
            chk("rd_wen", 64'(bus.rd_wen), 64'(e.wen));
            chk("busy_mask", 64'(bus.busy_mask), 64'(e.busy));
            chk("fast_stall", 64'(bus.fast_stall), 64'(e.stall));
            chk("slow_ready", 64'(bus.slow_ready), 64'(e.ready));
`ifdef WB_PERF_EN
            chk("perf_stall_cycles", 64'(perf_stall_cycles), 64'(e.pst));
            chk("perf_x0_drops", 64'(perf_x0_drops), 64'(e.px0));
`endif
            if (bus.rd_wen) begin
                if (wrq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=x%0d expected=none at %0t", bus.rd_addr, $time);
                end else begin
                    w = wrq.pop_front();
                    chk("rd_addr", 64'(bus.rd_addr), 64'(w.rd));
                    chk("rd_data", bus.rd_data, w.data);
                end
            end
        end
    end

    initial begin
        int fprob;
        bus.fast_valid = 1'b0;
        bus.fast_rd    = 5'd0;
        bus.fast_data  = 64'd0;
        bus.slow_valid = 1'b0;
        bus.slow_rd    = 5'd0;
        bus.slow_data  = 64'd0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

        step(1'b0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
        idle(2);
        step(1'b0, 1'b1, 5'd0, 64'hdead, 1'b0, 5'd0, 64'd0);
        idle(2);

        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h3333);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h7777);
        idle(4);

        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 5'(10 + i), 64'(100 + i), i < 5, 5'(20 + i), 64'(200 + i));
        idle(8);

        step(1'b0, 1'b1, 5'd2, 64'haaaa, 1'b1, 5'd2, 64'hbbbb);
        idle(4);

        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'(1 + i), 64'(i), 1'b1, 5'(11 + i), 64'(50 + i));
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        idle(6);

        for (int i = 0; i < 900; i++) begin
            logic [4:0] frd, srd;
            if (i % 100 == 0) fprob = (i / 100) % 3 == 0 ? 15 : ((i / 100) % 3 == 1 ? 55 : 95);
            frd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            srd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < fprob, frd, {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, srd, {$urandom, $urandom});
        end
        idle(12);

        @(negedge clk);
        #1;
        chk("writes_drained", 64'(wrq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter and the writer side of the integer register file's single write port.
- Merges two result sources into one registered write stream (rd_wen/rd_addr/rd_data):
  - a fast single-cycle path (ALU) with no backpressure;
  - a slow long-latency path (LSU/MUL-DIV) with valid/ready handshake.
- Slow results are buffered in a small FIFO and drained in cycles when the fast path is idle.
- Provides a busy mask for hazard detection and a starvation stall request.

Parameters:
- XLEN, 64, data width; taken from the shared defines.
- REG_ADDR_WIDTH, 5, register index width; taken from the shared defines.
- FIFO_DEPTH, 4, slow-path buffer entries; power of two, at least 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before fast_stall is raised; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- fast_valid  in  1  fast result present this cycle
- fast_rd  in  REG_ADDR_WIDTH  fast destination register
- fast_data  in  XLEN  fast result
- fast_stall  out  1  registered request that upstream hold fast_valid=0 next cycle
- slow_valid  in  1  slow result offered
- slow_ready  out  1  FIFO can accept
- slow_rd  in  REG_ADDR_WIDTH  slow destination register
- slow_data  in  XLEN  slow result
- rd_wen  out  1  regfile write enable (registered)
- rd_addr  out  REG_ADDR_WIDTH  regfile write address (registered)
- rd_data  out  XLEN  regfile write data (registered)
- busy_mask  out  32  bit i=1 means a write to register i is buffered or in flight

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: rd_wen=0, rd_addr=0, rd_data=0, fast_stall=0, busy_mask=0, slow_ready=0.
  - Reset empties the FIFO and clears the starvation counter.
  - Reset asserted mid-operation discards all buffered slow results; nothing is written afterwards.
- Selection, evaluated each cycle:
  - If fast_valid=1, the fast result is selected.
  - Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped.
  - Otherwise nothing is selected.
- Output register:
  - Loaded on the clock edge ending the selection cycle.
  - rd_wen = selected valid AND selected rd != 0; writes to x0 are dropped.
  - rd_addr and rd_data load only when rd_wen is set; otherwise they hold.
- Latency:
  - Fast path: rd_wen is visible 1 cycle after fast_valid.
  - Slow path: an accepted handshake in cycle N is popped no earlier than cycle N+1 and visible at N+2. There is no empty-FIFO bypass.
- Slow handshake:
  - An entry is enqueued when slow_valid AND slow_ready.
  - slow_ready = !full, combinational from the registered count.
  - When full, slow_ready=0, so no push can coincide with full. A push and a pop in the same cycle are legal at any other occupancy.
  - The FIFO preserves order: slow results commit in acceptance order.
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and the fast path wins.
  - starve_cnt clears on any pop or when the FIFO is empty.
  - fast_stall is registered: it is set the cycle after starve_cnt reaches STARVE_LIMIT and cleared the cycle after a pop.
  - If upstream ignores fast_stall, the fast path still wins and no data is lost.
- busy_mask (combinational):
  - OR of one-hot(rd) over valid FIFO entries, plus one-hot(rd_addr) when rd_wen=1; bit 0 is always 0.
  - The mask covers the interval until the regfile write lands at the following edge.
- Multiple entries for the same rd are allowed; the later one commits last.

Optional Feature:
- Macro: WB_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles (32, counts cycles with fast_stall=1) and perf_x0_drops (32, counts selected writes dropped for rd=0).
  - Both counters wrap and clear on rst.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared defines: XLEN, REG_ADDR_WIDTH, and a writeback-entry typedef {rd, data} used by the FIFO and the output register.
- Sub-module: wb_fifo, a synchronous FIFO with push/pop, count/full/empty, and per-entry valid+rd visibility for busy_mask.
- wb_arbiter instantiates wb_fifo and holds the selection, output register, starvation counter and mask logic.

Test Plan:
- Reset then fast_valid=1, fast_rd=5, fast_data=0x1234 -> next cycle rd_wen=1, rd_addr=5, rd_data=0x1234; busy_mask bit5=1 for that cycle only.
- fast_rd=0 with any data -> rd_wen stays 0; with WB_PERF_EN, perf_x0_drops increments by 1.
- With the fast path idle, push slow rd=3 then rd=7 -> rd_wen in order: x3 at N+2, x7 at N+3.
- Hold fast_valid=1 continuously with 4 slow pushes (FIFO_DEPTH=4) -> slow_ready=0 after the 4th push, fast_stall=1 after 8 blocked cycles; when upstream drops fast_valid, the head pops and fast_stall clears the next cycle.
- In the same cycle, fast rd=2 and a slow push rd=2 -> fast commits first, slow commits later; the final regfile value is the slow data.
- Assert rst with 3 entries buffered -> next cycle busy_mask=0, slow_ready=0, rd_wen=0; no buffered entry is ever written.
